subset_sum_engine: RTL

//   Clocked subset-sum search engine; sequential successor of the combinational node-tree checker.

---
 rtl/subset_sum_pkg.sv | 19 +
 rtl/gray_step_gen.sv | 48 ++++
 rtl/subset_sum_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/subset_sum_pkg.sv
// Shared types and helpers for the Gray-code subset-sum search engine.
package subset_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_BEST  = 1'b1;

  // Width that holds the sum of n operands of b bits each, all at maximum value
  function automatic int sum_width(input int n, input int b);
    return $clog2(n * ((2 ** b) - 1) + 1);
  endfunction

endpackage

// File: rtl/gray_step_gen.sv
// Gray-code step generator: for step k, names the element to flip (lowest set bit of k)
// and the value that bit takes in the new subset.
module gray_step_gen #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [IW-1:0] flip_idx,
  output logic          flip_set,
  output logic          last
);

  logic [N-1:0] step_r;
  logic [N-1:0] gray_s;

  // Step counter; clear primes it to step 1, ready for the first scan cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      step_r <= '0;
    end else if (clear) begin
      step_r <= N'(1);
    end else if (advance) begin
      step_r <= step_r + N'(1);
    end else begin
      step_r <= step_r;
    end
  end

  // Lowest set bit of the step selects the flipped element
  always_comb begin
    flip_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (step_r[i]) begin
        flip_idx = IW'(i);
      end else begin
        flip_idx = flip_idx;
      end
    end
  end

  assign gray_s   = step_r ^ (step_r >> 1);
  assign flip_set = gray_s[flip_idx];
  assign last     = (step_r == {N{1'b1}});

endmodule

// File: rtl/subset_sum_engine.sv
// Sequential subset-sum search: walks every subset in Gray order with one add or subtract
// per cycle, in exact-match or best-at-most mode.
module subset_sum_engine
  import subset_sum_pkg::*;
#(
  parameter int N_of_numbers = 5,
  parameter int N_of_bits    = 4,
  parameter int SUM_W        = sum_width(N_of_numbers, N_of_bits)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              mode,
  input  logic [N_of_numbers*N_of_bits-1:0] numbers_flat,
  input  logic [SUM_W-1:0]                  target,
  output logic                              busy,
  output logic                              done,
  output logic                              isTargetMet,
  output logic [N_of_numbers-1:0]           subset_mask,
  output logic [SUM_W-1:0]                  best_sum,
  output logic [N_of_numbers:0]             subsets_checked
);

  localparam int IW = $clog2(N_of_numbers);
  localparam int CW = N_of_numbers + 1;

  state_t                  state_r;
  logic [N_of_bits-1:0]    elems_r [N_of_numbers];
  logic [SUM_W-1:0]        target_r;
  logic                    mode_r;
  logic [N_of_numbers-1:0] cur_mask_r;
  logic [SUM_W-1:0]        cur_sum_r;

  logic [IW-1:0]           flip_idx_s;
  logic                    flip_set_s;
  logic                    last_s;
  logic [SUM_W-1:0]        elem_ext_s;
  logic [N_of_numbers-1:0] nxt_mask_s;
  logic [SUM_W-1:0]        nxt_sum_s;
  logic                    hit_s;
  logic                    better_s;

  gray_step_gen #(
    .N  (N_of_numbers),
    .IW (IW)
  ) u_gray (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_r == LOAD),
    .advance  (state_r == SCAN),
    .flip_idx (flip_idx_s),
    .flip_set (flip_set_s),
    .last     (last_s)
  );

  // Next subset, its sum, and how it compares against target and the best so far
  always_comb begin
    elem_ext_s = SUM_W'(elems_r[flip_idx_s]);
    nxt_mask_s = cur_mask_r;
    nxt_mask_s[flip_idx_s] = flip_set_s;
    if (flip_set_s) begin
      nxt_sum_s = cur_sum_r + elem_ext_s;
    end else begin
      nxt_sum_s = cur_sum_r - elem_ext_s;
    end
    hit_s = (nxt_sum_s == target_r);
    if (mode_r == MODE_BEST) begin
      better_s = (nxt_sum_s <= target_r) && (nxt_sum_s > best_sum);
    end else begin
      better_s = 1'b0;
    end
  end

  // Search FSM with operand latches, accumulator and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      isTargetMet     <= 1'b0;
      subset_mask     <= '0;
      best_sum        <= '0;
      subsets_checked <= '0;
      target_r        <= '0;
      mode_r          <= MODE_EXACT;
      cur_mask_r      <= '0;
      cur_sum_r       <= '0;
      for (int i = 0; i < N_of_numbers; i++) elems_r[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_of_numbers; i++) elems_r[i] <= numbers_flat[i*N_of_bits +: N_of_bits];
            target_r        <= target;
            mode_r          <= mode;
            isTargetMet     <= 1'b0;
            subset_mask     <= '0;
            best_sum        <= '0;
            subsets_checked <= '0;
            busy            <= 1'b1;
            state_r         <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (abort) begin
            isTargetMet <= 1'b0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cur_mask_r      <= '0;
            cur_sum_r       <= '0;
            subsets_checked <= CW'(1);
            if (target_r == '0) begin
              isTargetMet <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= SCAN;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            isTargetMet <= 1'b0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cur_mask_r      <= nxt_mask_s;
            cur_sum_r       <= nxt_sum_s;
            subsets_checked <= subsets_checked + CW'(1);
            if (hit_s) begin
              isTargetMet <= 1'b1;
              subset_mask <= nxt_mask_s;
              best_sum    <= nxt_sum_s;
              state_r     <= DONE;
            end else begin
              if (better_s) begin
                subset_mask <= nxt_mask_s;
                best_sum    <= nxt_sum_s;
              end else begin
                subset_mask <= subset_mask;
              end
              state_r <= last_s ? DONE : SCAN;
            end
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
